// File: rtl/bus_timeout.sv
`default_nettype none
// ============================================================================
// Module   : bus_timeout
// Brief    : Saturating cycle-count watchdog for bus transactions. Optional
//            single-cycle timeout pulse selected by macro TIMEOUT_PULSE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module bus_timeout #(
    parameter int TIMEOUT   = 10,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clear,
    input  logic                 enable,
    output logic                 timeout,
    output logic [CNT_WIDTH-1:0] count
);

    generate
        if (TIMEOUT < 1) begin : g_bad_timeout
            $error("bus_timeout: TIMEOUT must be at least 1");
        end
        if (CNT_WIDTH < 31) begin : g_width_check
            if (TIMEOUT > ((1 << CNT_WIDTH) - 1)) begin : g_bad_width
                $error("bus_timeout: CNT_WIDTH too narrow for TIMEOUT");
            end
        end
    endgenerate

    localparam logic [CNT_WIDTH-1:0] C_LIMIT = CNT_WIDTH'(TIMEOUT);

    logic [CNT_WIDTH-1:0] r_count;
    logic                 w_at_limit;

    assign w_at_limit = (r_count == C_LIMIT);

    // Saturates at the limit; clear outranks enable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && !w_at_limit) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

`ifdef TIMEOUT_PULSE_EN
    localparam logic [CNT_WIDTH-1:0] C_LIMIT_M1 = CNT_WIDTH'(TIMEOUT - 1);

    logic r_pulse;

    // Set only on the edge that moves the count onto the limit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pulse <= 1'b0;
        end else if (clear) begin
            r_pulse <= 1'b0;
        end else begin
            r_pulse <= enable && (r_count == C_LIMIT_M1);
        end
    end

    assign timeout = r_pulse;
`else
    assign timeout = w_at_limit;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bus_timeout.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_timeout
// Brief    : Directed scoreboard bench for bus_timeout (level or pulse mode).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_timeout;

`ifdef TIMEOUT_PULSE_EN
    localparam int   TO     = 3;
    localparam logic PULSE  = 1'b1;
`else
    localparam int   TO     = 10;
    localparam logic PULSE  = 1'b0;
`endif
    localparam int   CW     = 16;
    localparam logic SAT_TO = !PULSE;
    localparam int   ENA1   = (TO > 4) ? 4 : TO - 1;

    typedef struct packed {
        logic [CW-1:0] cnt;
        logic          to;
    } exp_t;

    logic          clk     = 1'b0;
    logic          reset_n = 1'b0;
    logic          clear   = 1'b1;
    logic          enable  = 1'b0;
    logic          timeout;
    logic [CW-1:0] count;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   m_cnt       = 0;
    logic m_to        = 1'b0;

    bus_timeout #(.TIMEOUT(TO), .CNT_WIDTH(CW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .enable  (enable),
        .timeout (timeout),
        .count   (count)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input int c, input logic t);
        exp_t x;
        x.cnt = CW'(c);
        x.to  = t;
        return x;
    endfunction

    task automatic check(input string tag, input exp_t e);
        vectors++;
        assert (count === e.cnt && timeout === e.to)
        else begin
            miscompares++;
            $error("FAIL %s: observed count=%0d timeout=%b, expected count=%0d timeout=%b",
                   tag, count, timeout, e.cnt, e.to);
        end
    endtask

    // Drive one edge's inputs, predict the result, compare after the edge.
    task automatic step(input logic c, input logic e, input string tag);
        int prev;
        @(negedge clk);
        clear  = c;
        enable = e;
        prev   = m_cnt;
        if (c)
            m_cnt = 0;
        else if (e && m_cnt < TO)
            m_cnt = m_cnt + 1;
        if (PULSE)
            m_to = !c && e && (prev == TO - 1);
        else
            m_to = (m_cnt == TO);
        sb.push_back(mk(m_cnt, m_to));
        @(posedge clk);
        #1;
        check(tag, sb.pop_front());
    endtask

    task automatic async_reset(input string tag);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check({tag, "_immediate"}, mk(0, 1'b0));
        @(posedge clk);
        #1 check({tag, "_held"}, mk(0, 1'b0));
        @(negedge clk);
        reset_n = 1'b1;
        clear   = 1'b0;
        enable  = 1'b0;
        m_cnt   = 0;
        m_to    = 1'b0;
        #1 check({tag, "_released"}, mk(0, 1'b0));
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1 check("reset_state", mk(0, 1'b0));
        @(negedge clk);
        reset_n = 1'b1;

        // Basic expiry
        repeat (3) step(1'b1, 1'b0, "clear_hold");
        for (int i = 1; i <= TO; i++) step(1'b0, 1'b1, "count_up");
        check("expiry", mk(TO, 1'b1));
        step(1'b0, 1'b1, "post_expiry");
        check("post_expiry_flag", mk(TO, SAT_TO));
        repeat (19) step(1'b0, 1'b1, "saturate");
        check("saturated", mk(TO, SAT_TO));

        // Enable gating
        step(1'b1, 1'b1, "gate_clear");
        repeat (ENA1) step(1'b0, 1'b1, "gate_count");
        repeat (5) step(1'b0, 1'b0, "gate_frozen");
        check("gate_frozen_value", mk(ENA1, 1'b0));
        repeat (TO - ENA1 - 1) step(1'b0, 1'b1, "gate_resume");
        check("gate_before_expiry", mk(TO - 1, 1'b0));
        step(1'b0, 1'b1, "gate_last");
        check("gate_expiry", mk(TO, 1'b1));

        // Restart mid-count and after expiry
        step(1'b1, 1'b0, "restart_clear");
        repeat (TO - 1) step(1'b0, 1'b1, "restart_partial");
        step(1'b1, 1'b1, "restart_pulse");
        check("restart_zero", mk(0, 1'b0));
        repeat (TO) step(1'b0, 1'b1, "restart_recount");
        check("restart_expiry", mk(TO, 1'b1));
        repeat (3) step(1'b0, 1'b1, "restart_saturate");
        step(1'b1, 1'b0, "clear_after_expiry");
        check("clear_after_expiry_zero", mk(0, 1'b0));

        // Clear beats enable
        repeat (5) step(1'b1, 1'b1, "priority");
        check("priority_zero", mk(0, 1'b0));

        // Asynchronous reset while saturated
        repeat (TO + 2) step(1'b0, 1'b1, "pre_reset");
        check("pre_reset_value", mk(TO, SAT_TO));
        async_reset("async_reset");
        step(1'b0, 1'b1, "first_after_reset");
        check("first_after_reset_value", mk(1, 1'b0));
        repeat (TO - 1) step(1'b0, 1'b1, "recount_after_reset");
        check("expiry_after_reset", mk(TO, 1'b1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
